// File: rtl/lcd_spi_arbiter_if.sv
// Bus bundle between the two LCD command sources, the arbiter and the
// 9-bit SPI word serializer. The arbiter takes the slave side.
interface lcd_spi_arbiter_if #(
    parameter int WORD_W = 9
);
    logic              req0_valid;
    logic [WORD_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;

    logic              req1_valid;
    logic [WORD_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;

    logic              ser_valid;
    logic [WORD_W-1:0] ser_data;
    logic              ser_last;
    logic              ser_ready;
    logic              ser_abort;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  ser_ready,
        output req0_ready, req1_ready,
        output ser_valid, ser_data, ser_last, ser_abort,
        output grant, busy
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output ser_ready,
        input  req0_ready, req1_ready,
        input  ser_valid, ser_data, ser_last, ser_abort,
        input  grant, busy
    );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Packet-level arbiter sharing the LCD SPI word serializer between the
// init sequencer (port 0) and the runtime command source (port 1).
// Round-robin per packet, enforced CS-high gap, stall-timeout abort.
module lcd_spi_arbiter #(
    parameter int WORD_W     = 9,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    lcd_spi_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_LOAD_I);
    localparam logic [15:0]      STALL_MAX = 16'(TIMEOUT - 1);

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last_owner, last_owner_next;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
    logic [15:0]      stall_cnt, stall_cnt_next;

    logic              owner_valid;
    logic              owner_last;
    logic [WORD_W-1:0] owner_data;
    logic              pkt_done;

    assign owner_valid = owner ? bus.req1_valid : bus.req0_valid;
    assign owner_last  = owner ? bus.req1_last  : bus.req0_last;
    assign owner_data  = owner ? bus.req1_data  : bus.req0_data;

    // State and counter registers; reset drops any packet in flight silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gap_cnt    <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            gap_cnt    <= gap_cnt_next;
            stall_cnt  <= stall_cnt_next;
        end
    end

    // Arbitration, combinational routing of the owner to the serializer,
    // end-of-packet / stall-timeout detection and gap countdown
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        gap_cnt_next    = gap_cnt;
        stall_cnt_next  = stall_cnt;
        pkt_done        = 1'b0;

        bus.ser_valid  = 1'b0;
        bus.ser_data   = '0;
        bus.ser_last   = 1'b0;
        bus.ser_abort  = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.grant      = 2'b00;
        bus.busy       = (state != IDLE);

        case (state)
            IDLE: begin
                stall_cnt_next = '0;
                if (bus.req0_valid && bus.req1_valid) begin
                    owner_next = ~last_owner;
                    state_next = XFER;
                end else if (bus.req0_valid) begin
                    owner_next = 1'b0;
                    state_next = XFER;
                end else if (bus.req1_valid) begin
                    owner_next = 1'b1;
                    state_next = XFER;
                end
            end

            XFER: begin
                bus.grant     = owner ? 2'b10 : 2'b01;
                bus.ser_valid = owner_valid;
                bus.ser_data  = owner_data;
                bus.ser_last  = owner_last;
                if (owner) begin
                    bus.req1_ready = bus.ser_ready;
                end else begin
                    bus.req0_ready = bus.ser_ready;
                end

                if (owner_valid && bus.ser_ready) begin
                    stall_cnt_next = '0;
                    pkt_done       = owner_last;
                end else if (!owner_valid) begin
                    if (stall_cnt == STALL_MAX) begin
                        bus.ser_abort = !rst;
                        pkt_done      = 1'b1;
                    end else begin
                        stall_cnt_next = stall_cnt + 16'd1;
                    end
                end

                if (pkt_done) begin
                    last_owner_next = owner;
                    if (GAP_CYCLES > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Randomised bench for lcd_spi_arbiter: two packet sources with random
// stalls, a serializer with random backpressure, a mid-packet reset, and
// a cycle-level behavioural model feeding a scoreboard.
module tb_lcd_spi_arbiter;

    localparam int W    = 9;
    localparam int GAP  = 4;
    localparam int TO   = 8;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_spi_arbiter_if #(.WORD_W(W)) bus ();

    lcd_spi_arbiter #(
        .WORD_W     (W),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sv;
        logic [W-1:0] sd;
        logic         sl;
        logic         ab;
        logic         r0;
        logic         r1;
        logic [1:0]   g;
        logic         b;
    } outs_t;

    typedef struct packed {
        logic [1:0]   g;
        logic [W-1:0] d;
        logic         l;
    } word_t;

    outs_t cyc_q[$];
    word_t word_q[$];

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;
    int cur_cyc = 0;

    // Source-side packet state: bit W of each word is the last flag
    logic [W:0] pkt_word [2][8];
    int pkt_len [2];
    int pkt_pos [2];
    int idle_left [2];
    int stall_left [2];
    int ready_low_left;

    // Reference model: current owner (-1 none), gap cycles left,
    // consecutive stall cycles, and last port served
    int m_owner;
    int m_gap;
    int m_stall;
    int m_last;

    task automatic new_packet(input int p);
        pkt_len[p] = $urandom_range(1, 4);
        pkt_pos[p] = 0;
        for (int i = 0; i < pkt_len[p]; i++) begin
            pkt_word[p][i][W-2:0] = 8'($urandom_range(0, 255));
            pkt_word[p][i][W-1]   = (i != 0);
            pkt_word[p][i][W]     = (i == pkt_len[p] - 1);
        end
    endtask

    task automatic apply_stimulus();
        logic vld [2];
        logic [W:0] w [2];
        for (int p = 0; p < 2; p++) begin
            if (pkt_pos[p] >= pkt_len[p]) begin
                if (idle_left[p] > 0) idle_left[p]--;
                else new_packet(p);
            end
            if (stall_left[p] > 0) stall_left[p]--;
            else if ($urandom_range(0, 19) == 0) stall_left[p] = $urandom_range(1, 12);
            vld[p] = (pkt_pos[p] < pkt_len[p]) && (stall_left[p] == 0);
            w[p]   = (pkt_pos[p] < pkt_len[p]) ? pkt_word[p][pkt_pos[p]] : '0;
        end
        bus.req0_valid = vld[0];
        bus.req0_data  = w[0][W-1:0];
        bus.req0_last  = w[0][W];
        bus.req1_valid = vld[1];
        bus.req1_data  = w[1][W-1:0];
        bus.req1_last  = w[1][W];

        if (ready_low_left > 0) begin
            ready_low_left--;
            bus.ser_ready = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
            ready_low_left = 9;
            bus.ser_ready  = 1'b0;
        end else begin
            bus.ser_ready = ($urandom_range(0, 4) != 0);
        end
    endtask

    task automatic model_step();
        outs_t e;
        word_t wq;
        logic v [2];
        logic l [2];
        logic [W-1:0] d [2];
        logic done;
        e    = '0;
        done = 1'b0;
        v[0] = bus.req0_valid; d[0] = bus.req0_data; l[0] = bus.req0_last;
        v[1] = bus.req1_valid; d[1] = bus.req1_data; l[1] = bus.req1_last;

        if (m_gap > 0) begin
            e.b = 1'b1;
            m_gap--;
        end else if (m_owner >= 0) begin
            e.b  = 1'b1;
            e.g  = (m_owner == 1) ? 2'b10 : 2'b01;
            e.sv = v[m_owner];
            e.sd = d[m_owner];
            e.sl = l[m_owner];
            if (m_owner == 0) e.r0 = bus.ser_ready;
            else              e.r1 = bus.ser_ready;
            if (v[m_owner] && bus.ser_ready) begin
                wq.g = e.g;
                wq.d = d[m_owner];
                wq.l = l[m_owner];
                word_q.push_back(wq);
                m_stall = 0;
                done    = l[m_owner];
            end else if (!v[m_owner]) begin
                if (m_stall == TO - 1) begin
                    e.ab = !rst;
                    done = 1'b1;
                end else begin
                    m_stall++;
                end
            end
            if (done) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = GAP;
            end
        end else begin
            if (v[0] && v[1]) m_owner = 1 - m_last;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
            m_stall = 0;
        end

        if (rst) begin
            m_owner = -1;
            m_gap   = 0;
            m_stall = 0;
            m_last  = 1;
        end
        cyc_q.push_back(e);
    endtask

    task automatic update_drivers();
        logic acc [2];
        acc[0] = bus.req0_valid && bus.req0_ready;
        acc[1] = bus.req1_valid && bus.req1_ready;
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && pkt_pos[p] < pkt_len[p]) begin
                pkt_pos[p]++;
                if (pkt_pos[p] == pkt_len[p]) idle_left[p] = $urandom_range(0, 3);
            end
        end
    endtask

    // Monitor: compare every cycle's outputs and every serializer handshake
    outs_t act;
    outs_t exp_o;
    word_t got_w;
    word_t exp_w;
    always @(negedge clk) begin
        if (run) begin
            #1;
            act.sv = bus.ser_valid;
            act.sd = bus.ser_data;
            act.sl = bus.ser_last;
            act.ab = bus.ser_abort;
            act.r0 = bus.req0_ready;
            act.r1 = bus.req1_ready;
            act.g  = bus.grant;
            act.b  = bus.busy;
            checks++;
            if (cyc_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL cycle %0d outputs: got %h, required an expected entry", cur_cyc, act);
            end else begin
                exp_o = cyc_q.pop_front();
                if (act !== exp_o) begin
                    errors++;
                    $display("[TB] FAIL cycle %0d outputs: got sv=%b sd=%h sl=%b ab=%b r0=%b r1=%b g=%b b=%b, required sv=%b sd=%h sl=%b ab=%b r0=%b r1=%b g=%b b=%b",
                             cur_cyc, act.sv, act.sd, act.sl, act.ab, act.r0, act.r1, act.g, act.b,
                             exp_o.sv, exp_o.sd, exp_o.sl, exp_o.ab, exp_o.r0, exp_o.r1, exp_o.g, exp_o.b);
                end
            end
            if (bus.ser_valid === 1'b1 && bus.ser_ready === 1'b1) begin
                got_w.g = bus.grant;
                got_w.d = bus.ser_data;
                got_w.l = bus.ser_last;
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cycle %0d word: got g=%b d=%h l=%b, required no transfer", cur_cyc, got_w.g, got_w.d, got_w.l);
                end else begin
                    exp_w = word_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("[TB] FAIL cycle %0d word: got g=%b d=%h l=%b, required g=%b d=%h l=%b",
                                 cur_cyc, got_w.g, got_w.d, got_w.l, exp_w.g, exp_w.d, exp_w.l);
                    end
                end
            end
        end
    end

    // Main stimulus loop: reset, random traffic, one mid-packet reset on port 1
    initial begin
        int rst_left;
        bit did_rst;
        rst_left = 3;
        did_rst  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pkt_len[p]    = 0;
            pkt_pos[p]    = 0;
            idle_left[p]  = 0;
            stall_left[p] = 0;
        end
        ready_low_left = 0;
        m_owner = -1;
        m_gap   = 0;
        m_stall = 0;
        m_last  = 1;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
        bus.ser_ready  = 1'b0;
        run = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst = 1'b0;
            end else if (!did_rst && c >= 1500 && m_owner == 1 && m_gap == 0) begin
                rst      = 1'b1;
                rst_left = 3;
                did_rst  = 1'b1;
            end
            apply_stimulus();
            @(negedge clk);
            model_step();
            update_drivers();
        end
        #3;
        run = 1'b0;

        checks++;
        if (!did_rst) begin
            errors++;
            $display("[TB] FAIL mid_packet_reset: got no port-1 transfer to reset, required one");
        end
        checks++;
        if (cyc_q.size() != 0 || word_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover: got %0d cycle / %0d word entries unmatched, required 0/0",
                     cyc_q.size(), word_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
